fir_tap_window: RTL and testbench
=================================

# fir_tap_window

Upstream feeder for the parallel-tap `fir` block. It accepts a serial stream of samples with a valid qualifier and keeps them in an NTAPS-deep shift register. The whole window is presented as a parallel tap array that connects directly to the `fir` `din` port. It drives the `fir` `EN` input with a one-cycle strobe each time a complete, optionally decimated window is ready.

## Interface

- DWIDTH, 15, sample width in bits, unsigned; matches `fir` DWIDTH
- NTAPS, 37, window depth; matches the `fir` tap count
- DECIM, 1, output decimation factor; legal range 1..NTAPS
- CLK  in  1  system clock; all state changes on the rising edge
- RST  in  1  reset, asynchronous, active-high
- din_valid  in  1  `din` holds a sample this cycle
- din  in  DWIDTH  serial input sample
- flush  in  1  synchronous clear of the window and the fill state
- taps  out  [DWIDTH-1:0] x NTAPS (unpacked)  tap window; connects to `fir` `din`
- EN  out  1  one-cycle strobe: `taps` holds a new complete window; connects to `fir` `EN`
- fill_cnt  out  $clog2(NTAPS+1)  number of samples accepted since reset or flush, saturates at NTAPS
- full  out  1  high in state RUN

## Operation

- Tap ordering
  - `taps[0]` is the newest sample.
  - `taps[NTAPS-1]` is the oldest sample.
- Accept: `din_valid`=1 and `flush`=0 at a rising edge accepts the sample.
  - `taps[k] <= taps[k-1]` for k = 1..NTAPS-1.
  - `taps[0] <= din`.
- States: EMPTY, FILL, RUN.
  - EMPTY: entered on reset or flush; `fill_cnt`=0. The first accept moves to FILL, or straight to RUN if NTAPS==1.
  - FILL: each accept increments `fill_cnt`. The accept that brings `fill_cnt` to NTAPS moves to RUN.
  - RUN: `fill_cnt` holds at NTAPS; `full`=1. Leaves RUN only on flush or reset.
- Decimation counter `dphase` (0..DECIM-1)
  - The accept that enters RUN sets `dphase` to 1 mod DECIM and raises EN.
  - In RUN, each accept with `dphase`==0 raises EN, then increments `dphase` with wrap DECIM-1 -> 0.
  - Accepts with `dphase`!=0 shift the taps but do not raise EN.
  - With DECIM=1, every accept in RUN raises EN.
- EN rules
  - EN is registered.
  - EN is high for exactly the one cycle following the qualifying accept edge, concurrent with the updated `taps`.
  - EN is never high in EMPTY or FILL, except on the transition accept into RUN.
  - Cycles with `din_valid`=0 never raise EN and never change `taps`.
- Flush
  - `flush`=1 at an edge sets all taps to 0, `fill_cnt` to 0, `dphase` to 0, EN to 0, and the state to EMPTY.
  - `flush` has priority over a simultaneous `din_valid`; that sample is dropped.
- Back-to-back operation: `din_valid` may be high every cycle. There is no backpressure, so every sample is accepted.

## Timing

- Reset values: all `taps`=0, EN=0, `fill_cnt`=0, `full`=0, state EMPTY, `dphase`=0.
- Reset behaviour
  - Asserting RST clears all state immediately, without waiting for a clock edge, at any point including mid-fill.
  - After RST deasserts, the first accept occurs no earlier than the next rising edge.
- Latency: the sample accepted at edge n appears in `taps[0]` after edge n; the EN strobe for that window is high from edge n to edge n+1. `fir` samples the window at edge n+1.
- Fill: the first EN follows the NTAPS-th accept after reset or flush, regardless of `din_valid` gaps.
- Decimated rate: in RUN with continuous input, EN pulses every DECIM cycles. With gaps, EN pulses every DECIM accepts.
- Outputs are driven from registers only; no combinational path from `din` or `din_valid` to any output.

## Test plan

- Reset: hold RST for 10 clocks with `din_valid` toggling -> all `taps`=0, EN=0, `fill_cnt`=0, `full`=0 throughout. Release RST -> outputs unchanged until the first accept.
- Impulse fill, DECIM=1: after reset, feed 1 then 36 zeros back-to-back.
  - EN pulses once, in the cycle after the 37th accept, with `taps[36]`=1, all other taps 0, and `full`=1.
  - There is no EN before that cycle.
- Ramp with gaps: feed samples 1..40 with `din_valid` high on alternate cycles.
  - The first EN follows sample 37, showing `taps[0]`=37 and `taps[36]`=1.
  - EN then pulses after samples 38, 39 and 40 only, never in idle cycles; after 40, `taps[0]`=40 and `taps[36]`=4.
- Decimation, DECIM=4: fill with 37 samples, then 12 more continuously.
  - EN fires after accepts 37, 41, 45 and 49 only.
  - At the last pulse, `taps[0]` equals sample 49.
- Flush collision: in RUN, assert `flush` with `din_valid`=1 and `din`=5.
  - Next cycle: all taps 0, `fill_cnt`=0, `full`=0, EN=0; the 5 is absent.
  - Exactly 37 further accepts are needed for the next EN.
- Async reset mid-fill: assert RST between clock edges after 20 accepts -> outputs clear before the next edge; the refill then needs 37 accepts to produce EN.

Source files
------------

// File: rtl/fir_tap_window_if.sv
// rtl/fir_tap_window_if.sv - sample stream in, tap window and status out for fir_tap_window
interface fir_tap_window_if #(
   parameter int DWIDTH = 15,
   parameter int NTAPS  = 37
);
   localparam int CW = $clog2(NTAPS + 1);

   logic              din_valid;
   logic [DWIDTH-1:0] din;
   logic              flush;
   logic [DWIDTH-1:0] taps [NTAPS];
   logic              en;
   logic [CW-1:0]     fill_cnt;
   logic              full;

   modport master (
      output din_valid, din, flush,
      input  taps, en, fill_cnt, full
   );

   modport slave (
      input  din_valid, din, flush,
      output taps, en, fill_cnt, full
   );
endinterface

// File: rtl/fir_tap_window.sv
// rtl/fir_tap_window.sv - NTAPS-deep sample window with fill tracking and decimated EN strobe
module fir_tap_window #(
   parameter int DWIDTH = 15,
   parameter int NTAPS  = 37,
   parameter int DECIM  = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   fir_tap_window_if.slave  bus
);
   localparam int CW = $clog2(NTAPS + 1);
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

   // last fill count before the window is complete
   localparam logic [CW-1:0] CNT_LAST = CW'(NTAPS - 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);
   // the accept entering RUN already consumed phase 0
   localparam logic [PW-1:0] PH_ENTRY = PW'(1 % DECIM);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FILL  = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t            state_q,    state_d;
   logic [CW-1:0]     fill_cnt_q, fill_cnt_d;
   logic [PW-1:0]     dphase_q,   dphase_d;
   logic              en_q,       en_d;
   logic [DWIDTH-1:0] taps_q [NTAPS];
   logic [DWIDTH-1:0] taps_d [NTAPS];

   // next-state: flush wins over a same-cycle sample; otherwise shift on accept and advance fill/decimation
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      dphase_d   = dphase_q;
      en_d       = 1'b0;
      taps_d     = taps_q;
      if (bus.flush) begin
         state_d    = S_EMPTY;
         fill_cnt_d = '0;
         dphase_d   = '0;
         for (int k = 0; k < NTAPS; k++) begin
            taps_d[k] = '0;
         end
      end else if (bus.din_valid) begin
         taps_d[0] = bus.din;
         for (int k = 1; k < NTAPS; k++) begin
            taps_d[k] = taps_q[k-1];
         end
         unique case (state_q)
            S_EMPTY, S_FILL: begin
               fill_cnt_d = fill_cnt_q + CW'(1);
               if (fill_cnt_q == CNT_LAST) begin
                  state_d  = S_RUN;
                  en_d     = 1'b1;
                  dphase_d = PH_ENTRY;
               end else begin
                  state_d  = S_FILL;
               end
            end
            S_RUN: begin
               en_d     = (dphase_q == '0);
               dphase_d = (dphase_q == PH_LAST) ? '0 : dphase_q + PW'(1);
            end
            default: begin
               state_d = S_EMPTY;
            end
         endcase
      end
   end

   // state register; reset clears the window immediately, independent of the clock
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_EMPTY;
         fill_cnt_q <= '0;
         dphase_q   <= '0;
         en_q       <= 1'b0;
         taps_q     <= '{default: '0};
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         dphase_q   <= dphase_d;
         en_q       <= en_d;
         taps_q     <= taps_d;
      end
   end

   assign bus.taps     = taps_q;
   assign bus.en       = en_q;
   assign bus.fill_cnt = fill_cnt_q;
   assign bus.full     = (state_q == S_RUN);
endmodule

// File: tb/tb_fir_tap_window.sv
// tb/tb_fir_tap_window.sv - scoreboard bench for fir_tap_window with DECIM=1 and DECIM=4 instances
module tb_fir_tap_window;
   localparam int DW    = 15;
   localparam int NT    = 37;
   localparam int DEC_A = 1;
   localparam int DEC_B = 4;
   localparam int WW    = NT * DW;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   logic [WW-1:0] q_a [$];
   logic [WW-1:0] q_b [$];
   logic [DW-1:0] mdl_win [NT];
   int            acc_n;

   fir_tap_window_if #(.DWIDTH(DW), .NTAPS(NT)) ifa ();
   fir_tap_window_if #(.DWIDTH(DW), .NTAPS(NT)) ifb ();

   fir_tap_window #(.DWIDTH(DW), .NTAPS(NT), .DECIM(DEC_A)) dut_a (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifa)
   );

   fir_tap_window #(.DWIDTH(DW), .NTAPS(NT), .DECIM(DEC_B)) dut_b (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [WW-1:0] pack(input logic [DW-1:0] t [NT]);
      logic [WW-1:0] r;
      for (int k = 0; k < NT; k++) r[k*DW +: DW] = t[k];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_win(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // pop the expected window whenever a DUT strobes EN; an EN with nothing queued is an error
   always @(negedge clk) begin
      if (ifa.en !== 1'b0) begin
         checks++;
         assert (q_a.size() != 0) else begin
            errors++;
            $error("FAIL en_a_unexpected: observed en=%b expected no strobe", ifa.en);
         end
         if (q_a.size() != 0) chk_win("win_a", pack(ifa.taps), q_a.pop_front());
      end
      if (ifb.en !== 1'b0) begin
         checks++;
         assert (q_b.size() != 0) else begin
            errors++;
            $error("FAIL en_b_unexpected: observed en=%b expected no strobe", ifb.en);
         end
         if (q_b.size() != 0) chk_win("win_b", pack(ifb.taps), q_b.pop_front());
      end
   end

   task automatic drv(input logic v, input logic [DW-1:0] d, input logic f);
      ifa.din_valid = v; ifa.din = d; ifa.flush = f;
      ifb.din_valid = v; ifb.din = d; ifb.flush = f;
   endtask

   task automatic mdl_clear();
      acc_n = 0;
      for (int k = 0; k < NT; k++) mdl_win[k] = '0;
   endtask

   // one clock of stimulus; the reference window and EN expectations are updated as it is driven
   task automatic step(input logic v, input int d, input logic f);
      @(negedge clk);
      drv(v, DW'(d), f);
      if (f) begin
         mdl_clear();
      end else if (v) begin
         for (int k = NT - 1; k > 0; k--) mdl_win[k] = mdl_win[k-1];
         mdl_win[0] = DW'(d);
         acc_n++;
         if (acc_n >= NT && ((acc_n - NT) % DEC_A) == 0) q_a.push_back(pack(mdl_win));
         if (acc_n >= NT && ((acc_n - NT) % DEC_B) == 0) q_b.push_back(pack(mdl_win));
      end
      @(posedge clk);
      #1;
      drv(1'b0, '0, 1'b0);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_taps_a"}, 64'(pack(ifa.taps) == '0), 64'(1));
      chk({tag, "_taps_b"}, 64'(pack(ifb.taps) == '0), 64'(1));
      chk({tag, "_en"},     64'({ifa.en, ifb.en}), 64'(0));
      chk({tag, "_fill"},   64'({ifa.fill_cnt, ifb.fill_cnt}), 64'(0));
      chk({tag, "_full"},   64'({ifa.full, ifb.full}), 64'(0));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mdl_clear();
      rst = 1'b1;
      drv(1'b0, '0, 1'b0);

      // reset held with din_valid toggling
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drv(1'(i % 2), DW'(i + 7), 1'b0);
         @(posedge clk);
         #1;
         chk_idle("rst_hold");
      end
      @(negedge clk);
      drv(1'b0, '0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 0, 1'b0);
         chk_idle("post_rst");
      end

      // impulse fill
      step(1'b1, 1, 1'b0);
      for (int i = 0; i < 35; i++) step(1'b1, 0, 1'b0);
      chk("imp_fill36", 64'(ifa.fill_cnt), 64'(36));
      chk("imp_full36", 64'(ifa.full), 64'(0));
      step(1'b1, 0, 1'b0);
      chk("imp_en", 64'(ifa.en), 64'(1));
      chk("imp_full", 64'(ifa.full), 64'(1));
      chk("imp_fill37", 64'(ifa.fill_cnt), 64'(37));
      chk("imp_tap36", 64'(ifa.taps[36]), 64'(1));
      chk("imp_tap0", 64'(ifa.taps[0]), 64'(0));

      // ramp with alternate idle cycles
      step(1'b0, 0, 1'b1);
      chk_idle("flush1");
      for (int i = 1; i <= 40; i++) begin
         step(1'b1, i, 1'b0);
         if (i == 37) begin
            chk("ramp_en37", 64'(ifa.en), 64'(1));
            chk("ramp_tap0_37", 64'(ifa.taps[0]), 64'(37));
            chk("ramp_tap36_37", 64'(ifa.taps[36]), 64'(1));
         end
         step(1'b0, 0, 1'b0);
         chk("ramp_idle_en", 64'(ifa.en), 64'(0));
      end
      chk("ramp_tap0_40", 64'(ifa.taps[0]), 64'(40));
      chk("ramp_tap36_40", 64'(ifa.taps[36]), 64'(4));

      // decimation by 4 on dut_b, continuous input
      step(1'b0, 0, 1'b1);
      for (int i = 1; i <= 49; i++) begin
         step(1'b1, 200 + i, 1'b0);
         if (i == 48) chk("dec_en48", 64'(ifb.en), 64'(0));
      end
      chk("dec_en49", 64'(ifb.en), 64'(1));
      chk("dec_tap0_49", 64'(ifb.taps[0]), 64'(249));
      chk("dec_full", 64'(ifb.full), 64'(1));

      // flush colliding with a valid sample while in RUN
      step(1'b1, 5, 1'b1);
      chk_idle("flush_col");
      for (int i = 1; i <= 36; i++) step(1'b1, 300 + i, 1'b0);
      chk("col_fill36", 64'(ifa.fill_cnt), 64'(36));
      step(1'b1, 337, 1'b0);
      chk("col_en", 64'({ifa.en, ifb.en}), 64'(3));
      chk("col_tap36", 64'(ifa.taps[36]), 64'(301));

      // asynchronous reset between edges after 20 accepts
      step(1'b0, 0, 1'b1);
      for (int i = 1; i <= 20; i++) step(1'b1, 400 + i, 1'b0);
      chk("ar_fill20", 64'(ifa.fill_cnt), 64'(20));
      #2;
      rst = 1'b1;
      #1;
      chk_idle("async_rst");
      mdl_clear();
      @(negedge clk);
      rst = 1'b0;
      for (int i = 1; i <= 36; i++) step(1'b1, 500 + i, 1'b0);
      chk("ar_en36", 64'({ifa.en, ifb.en}), 64'(0));
      step(1'b1, 537, 1'b0);
      chk("ar_en37", 64'({ifa.en, ifb.en}), 64'(3));
      chk("ar_fill37", 64'(ifb.fill_cnt), 64'(37));

      for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b0);
      chk("q_a_drained", 64'(q_a.size()), 64'(0));
      chk("q_b_drained", 64'(q_b.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
